pulse_timer_mc: RTL

- Multi-channel successor to the single-channel edge timer.
- For each of NUM_CH channels, measures high-pulse widths (and optionally low periods) in clock cycles, between edge strobes from the upstream edge detectors.
- Each measurement is captured into a per-channel result register, flagged for saturation and overrun, and handed downstream with a per-channel valid/ready handshake.
- Sits between the edge-detect stage and the bit-decode stage of the pipeline.

---
 rtl/pipeline_types.sv | 29 ++
 rtl/pulse_timer_channel.sv | 145 ++++++++++++++
 rtl/pulse_timer_mc.sv | 49 ++++
 3 files changed

// File: rtl/pipeline_types.sv
// Shared pipeline types for the edge-detect -> pulse-timer -> bit-decode path.
//   edges_t        : single-cycle rising/falling strobes from an edge detector
//   pt_state_e     : per-channel pulse timer state
//   pulse_result_t : one captured measurement {width, level, sat, overrun}
// The result width field is PT_WIDTH bits wide. Timers built with a narrower
// counter zero-extend their measurement into it.
package pipeline_types;

  localparam int PT_WIDTH = 10;

  typedef struct packed {
    logic rising;
    logic falling;
  } edges_t;

  typedef enum logic [1:0] {
    PT_IDLE = 2'd0,
    PT_HIGH = 2'd1,
    PT_LOW  = 2'd2
  } pt_state_e;

  typedef struct packed {
    logic [PT_WIDTH-1:0] width;    // measured length in clock cycles
    logic                level;    // 1 = high pulse, 0 = low period
    logic                sat;      // counter hit its maximum value
    logic                overrun;  // replaced a result that was never taken
  } pulse_result_t;

endpackage

// File: rtl/pulse_timer_channel.sv
// One pulse-timer channel: state machine, width counter, result register and
// valid/ready handshake.
// Optional feature macro: PULSE_TIMER_TIMEOUT_EN (idle-low timeout strobe).
// Ports:
//   i_clk      clock
//   i_reset_n  asynchronous active-low reset
//   i_edges    rising/falling strobes for this channel
//   i_ready    downstream takes the held result this cycle
//   o_valid    a result is held
//   o_result   the held result
//   o_busy     channel is timing (HIGH or LOW)
//   o_timeout  one-cycle strobe when the idle-low threshold is reached
module pulse_timer_channel
  import pipeline_types::*;
#(
  parameter int WIDTH          = 10,
  parameter int MEASURE_LOW    = 0,
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  edges_t        i_edges,
  input  logic          i_ready,
  output logic          o_valid,
  output pulse_result_t o_result,
  output logic          o_busy,
  output logic          o_timeout
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  if (WIDTH < 1 || WIDTH > PT_WIDTH) begin : g_bad_width
    $error("pulse_timer_channel: WIDTH must be in 1..PT_WIDTH");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2**WIDTH) begin : g_bad_timeout
    $error("pulse_timer_channel: TIMEOUT_CYCLES must be in 1..2**WIDTH-1");
  end

  pt_state_e        state, state_d;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic             rise, fall;
  logic             capture;
  logic             timeout_hit;
  pulse_result_t    cap_result;

  assign rise    = i_edges.rising;
  assign fall    = i_edges.falling;
  // Falling is handled before rising, so a HIGH channel seeing both strobes
  // still captures; a LOW channel captures only on rising.
  assign capture = (state == PT_HIGH && fall) || (state == PT_LOW && rise);
  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;

  always_comb begin
    cap_result         = '0;
    cap_result.width   = PT_WIDTH'(cnt_inc);
    cap_result.level   = (state == PT_HIGH);
    cap_result.sat     = (cnt_inc == CNT_MAX);
    // Only a load over an untaken result is an overrun; a load in the same
    // cycle as a transfer is clean.
    cap_result.overrun = o_valid && !i_ready;
  end

`ifdef PULSE_TIMER_TIMEOUT_EN
  // The idle timer arms when a high pulse ends without a restart. With
  // MEASURE_LOW=0 it runs while the FSM sits in IDLE after that pulse.
  localparam logic [WIDTH-1:0] IDLE_LAST = WIDTH'(TIMEOUT_CYCLES - 1);

  logic             idle_armed;
  logic [WIDTH-1:0] idle_cnt;
  logic             arm;

  assign arm         = (state == PT_HIGH) && fall && !rise;
  assign timeout_hit = idle_armed && !rise && (idle_cnt == IDLE_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idle_armed <= 1'b0;
      idle_cnt   <= '0;
    end else if (arm) begin
      idle_armed <= 1'b1;
      idle_cnt   <= '0;
    end else if (rise || timeout_hit) begin
      idle_armed <= 1'b0;
      idle_cnt   <= '0;
    end else if (idle_armed) begin
      idle_cnt   <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= PT_IDLE;
    // NOTE: registers take non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    else            state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment up front keeps every path assigned, so no
    // latch is inferred for state_d.
    state_d = state;
    unique case (state)
      PT_IDLE: if (rise) state_d = PT_HIGH;
      PT_HIGH: if (fall && !rise) state_d = (MEASURE_LOW != 0) ? PT_LOW : PT_IDLE;
      PT_LOW: begin
        if (rise)             state_d = PT_HIGH;
        else if (timeout_hit) state_d = PT_IDLE;
      end
      default: state_d = PT_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    o_busy    = (state != PT_IDLE);
    o_timeout = timeout_hit;
  end

  // Counter, result register and handshake.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt      <= '0;
      o_valid  <= 1'b0;
      // NOTE: the result register is reset as well, so downstream never sees
      // stale fields after reset even though o_valid qualifies them.
      o_result <= '0;
    end else begin
      if (rise || capture || state_d == PT_IDLE) cnt <= '0;
      else                                       cnt <= cnt_inc;

      if (capture) begin
        o_valid  <= 1'b1;
        o_result <= cap_result;
      end else if (o_valid && i_ready) begin
        o_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pulse_timer_mc.sv
// Multi-channel pulse timer: NUM_CH independent pulse_timer_channel instances,
// each measuring high pulses (and low periods when MEASURE_LOW=1) between
// edge strobes and handing results downstream with valid/ready.
// Optional feature macro: PULSE_TIMER_TIMEOUT_EN (per-channel idle timeout).
// Ports:
//   i_clk      clock
//   i_reset_n  asynchronous active-low reset
//   i_edges    per-channel rising/falling strobes
//   i_ready    per-channel downstream ready
//   o_valid    per-channel result valid
//   o_result   per-channel result {width, level, sat, overrun}
//   o_busy     per-channel timing in progress
//   o_timeout  per-channel one-cycle idle-timeout strobe
module pulse_timer_mc
  import pipeline_types::*;
#(
  parameter int WIDTH          = 10,
  parameter int NUM_CH         = 4,
  parameter int MEASURE_LOW    = 0,
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  edges_t        [NUM_CH-1:0] i_edges,
  input  logic          [NUM_CH-1:0] i_ready,
  output logic          [NUM_CH-1:0] o_valid,
  output pulse_result_t [NUM_CH-1:0] o_result,
  output logic          [NUM_CH-1:0] o_busy,
  output logic          [NUM_CH-1:0] o_timeout
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pulse_timer_channel #(
      .WIDTH          (WIDTH),
      .MEASURE_LOW    (MEASURE_LOW),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_channel (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_edges   (i_edges[ch]),
      .i_ready   (i_ready[ch]),
      .o_valid   (o_valid[ch]),
      .o_result  (o_result[ch]),
      .o_busy    (o_busy[ch]),
      .o_timeout (o_timeout[ch])
    );
  end

endmodule
